// File: rtl/bsg_dff_chain_credit_sink.sv
// rtl/bsg_dff_chain_credit_sink.sv - credit-returning receive FIFO at the far end of a register chain
//
// Purpose: absorbs every beat delivered by an upstream fixed-latency chain into
// a circular buffer of els_p entries and returns one registered credit pulse per
// dequeued entry, so the sender (holding els_p credits out of reset) never needs
// a ready signal.
//
// Ports:
//   clk_i       clock, all logic on posedge
//   reset_n_i   synchronous active-low reset
//   v_i/data_i  beat from the chain output (always absorbed if a slot is free)
//   v_o/data_o  FIFO head; data_o is don't-care while v_o=0
//   yumi_i      consumer takes the head this cycle
//   credit_o    one-cycle credit pulse, the cycle after each accepted dequeue
//   count_o     current occupancy
//   overflow_o  sticky: a beat arrived while full and not draining
module bsg_dff_chain_credit_sink #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       yumi_i,
    output logic                       credit_o,
    output logic [$clog2(els_p+1)-1:0] count_o,
    output logic                       overflow_o
);

    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);

    localparam logic [ptr_w-1:0] last_ptr = ptr_w'(els_p - 1);
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(els_p);

    logic [width_p-1:0] mem_q [els_p];
    logic [width_p-1:0] mem_d [els_p];
    logic [ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [cnt_w-1:0]   count_q, count_d;
    logic               credit_q, credit_d;
    logic               overflow_q, overflow_d;

    logic full;
    logic deq;
    logic enq;

    always_comb begin
        full = (count_q == full_cnt);
        // yumi_i on an empty FIFO is ignored entirely.
        deq  = yumi_i && (count_q != '0);
        // When full, a same-cycle dequeue frees the slot the beat is written into.
        enq  = v_i && (!full || deq);

        rd_ptr_d = rd_ptr_q;
        if (deq) begin
            rd_ptr_d = (rd_ptr_q == last_ptr) ? '0 : rd_ptr_q + 1'b1;
        end

        wr_ptr_d = wr_ptr_q;
        if (enq) begin
            wr_ptr_d = (wr_ptr_q == last_ptr) ? '0 : wr_ptr_q + 1'b1;
        end

        count_d = count_q;
        if (enq && !deq) begin
            count_d = count_q + 1'b1;
        end else if (deq && !enq) begin
            count_d = count_q - 1'b1;
        end

        mem_d = mem_q;
        if (enq) begin
            mem_d[wr_ptr_q] = data_i;
        end

        credit_d   = deq;
        overflow_d = overflow_q || (v_i && full && !deq);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign v_o        = (count_q != '0);
    assign data_o     = mem_q[rd_ptr_q];
    assign credit_o   = credit_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule
